clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint_if.sv | 24 ++
 rtl/clint.sv | 137 +++++++++++++
 tb/tb_clint.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/clint_if.sv
// Request/response bus between a requester and the CLINT register block.
// One request in flight at a time; the response is held until accepted.
interface clint_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime behind
// a two-state request/response bus, driving the timer and software interrupts.
module clint #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int          TICK_DIV  = 1
) (
   input  logic    clk,
   input  logic    rst,
   clint_if.slave  bus,
   output logic    clint_mtip,
   output logic    clint_msip
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;
   localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

   logic [0:0]  state_q, state_d;
   logic [7:0]  presc_q, presc_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic        mtip_q, mtip_d;
   logic        resp_valid_q, resp_valid_d;
   logic [63:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic [63:0] aligned_addr;
   logic [63:0] offset;
   logic        in_range;
   logic        hit_msip, hit_cmp, hit_time, mapped;
   logic        accept, do_write;
   logic [63:0] byte_mask;
   logic [63:0] rd_sel;

   for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign byte_mask[gi*8 +: 8] = {8{bus.req_wstrb[gi]}};
   end

   always_comb begin
      aligned_addr = {bus.req_addr[63:3], 3'b000};
      offset       = aligned_addr - BASE_ADDR;
      // Subtraction wraps for addresses below the base, so check both ends.
      in_range     = (aligned_addr >= BASE_ADDR) && (offset[63:16] == 48'd0);
      hit_msip     = in_range && (offset[15:0] == 16'h0000);
      hit_cmp      = in_range && (offset[15:0] == 16'h4000);
      hit_time     = in_range && (offset[15:0] == 16'hBFF8);
      mapped       = hit_msip || hit_cmp || hit_time;
      accept       = bus.req_valid && (state_q == ST_IDLE);
      do_write     = accept && bus.req_wen && (bus.req_wstrb != 8'd0);

      rd_sel = 64'd0;
      if (hit_msip) rd_sel = {63'd0, msip_q};
      if (hit_cmp)  rd_sel = mtimecmp_q;
      if (hit_time) rd_sel = mtime_q;
   end

   always_comb begin
      presc_d      = presc_q;
      mtime_d      = mtime_q;
      mtimecmp_d   = mtimecmp_q;
      msip_d       = msip_q;
      state_d      = state_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      if (presc_q == TICK_LAST) begin
         presc_d = 8'd0;
         mtime_d = mtime_q + 64'd1;
      end else begin
         presc_d = presc_q + 8'd1;
      end

      // A bus write to mtime overrides this cycle's tick and restarts the prescaler.
      if (do_write && hit_time) begin
         mtime_d = (mtime_q & ~byte_mask) | (bus.req_wdata & byte_mask);
         presc_d = 8'd0;
      end
      if (do_write && hit_cmp)
         mtimecmp_d = (mtimecmp_q & ~byte_mask) | (bus.req_wdata & byte_mask);
      if (do_write && hit_msip && bus.req_wstrb[0])
         msip_d = bus.req_wdata[0];

      mtip_d = (mtime_d >= mtimecmp_d);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = !mapped;
               resp_rdata_d = bus.req_wen ? 64'd0 : rd_sel;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
               resp_rdata_d = 64'd0;
               resp_err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         presc_q      <= 8'd0;
         mtime_q      <= 64'd0;
         mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip_q       <= 1'b0;
         mtip_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 64'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         msip_q       <= msip_d;
         mtip_q       <= mtip_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign clint_mtip     = mtip_q;
   assign clint_msip     = msip_q;
endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one instance with TICK_DIV=1, one with TICK_DIV=4,
// sharing request fields but with separate valid and reset lines.
module tb_clint;
   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst4, rv1, rv4, wen, resp_ready, sel4;
   logic [63:0] addr, wdata;
   logic [7:0]  wstrb;
   logic        mtip1, msip1, mtip4, msip4;
   logic        s_ready, s_rvalid, s_err;
   logic [63:0] s_rdata;
   logic [63:0] rd;
   logic        er;
   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc1 = 0;

   clint_if bus1();
   clint_if bus4();

   assign bus1.req_valid  = rv1;
   assign bus1.req_wen    = wen;
   assign bus1.req_addr   = addr;
   assign bus1.req_wdata  = wdata;
   assign bus1.req_wstrb  = wstrb;
   assign bus1.resp_ready = resp_ready;
   assign bus4.req_valid  = rv4;
   assign bus4.req_wen    = wen;
   assign bus4.req_addr   = addr;
   assign bus4.req_wdata  = wdata;
   assign bus4.req_wstrb  = wstrb;
   assign bus4.resp_ready = resp_ready;

   assign s_ready  = sel4 ? bus4.req_ready  : bus1.req_ready;
   assign s_rvalid = sel4 ? bus4.resp_valid : bus1.resp_valid;
   assign s_rdata  = sel4 ? bus4.resp_rdata : bus1.resp_rdata;
   assign s_err    = sel4 ? bus4.resp_err   : bus1.resp_err;

   clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst1), .bus(bus1), .clint_mtip(mtip1), .clint_msip(msip1)
   );
   clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
      .clk(clk), .rst(rst4), .bus(bus4), .clint_mtip(mtip4), .clint_msip(msip4)
   );

   // Reference count of edges since reset; equals dut1 mtime while untouched.
   always @(posedge clk) cyc1 <= rst1 ? 0 : cyc1 + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s, input int stall,
                      output logic [63:0] rdata, output logic err);
      int n;
      wen = wr; addr = a; wdata = d; wstrb = s;
      resp_ready = (stall == 0);
      n = 0;
      while (!s_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!s_ready) check("ready_timeout", {63'd0, s_ready}, 64'd1);
      if (sel4) rv4 = 1'b1; else rv1 = 1'b1;
      @(posedge clk); #1;
      rv1 = 1'b0; rv4 = 1'b0;
      n = 0;
      while (!s_rvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (!s_rvalid) check("resp_timeout", {63'd0, s_rvalid}, 64'd1);
      rdata = s_rdata;
      err   = s_err;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall_valid", {63'd0, s_rvalid}, 64'd1);
         check("stall_rdata", s_rdata, rdata);
         check("stall_err",   {63'd0, s_err}, {63'd0, err});
         check("stall_ready", {63'd0, s_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      $display("[TB] dut%0d %s addr=%h wdata=%h wstrb=%h -> rdata=%h err=%0d",
               sel4 ? 4 : 1, wr ? "WR" : "RD", a, d, s, rdata, err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sel4 = 1'b0; rst1 = 1'b1; rst4 = 1'b1; rv1 = 1'b0; rv4 = 1'b0;
      wen = 1'b0; addr = 64'd0; wdata = 64'd0; wstrb = 8'd0; resp_ready = 1'b1;
      @(posedge clk); #1;
      rst1 = 1'b0;
      check("rst_mtip",   {63'd0, mtip1}, 64'd0);
      check("rst_msip",   {63'd0, msip1}, 64'd0);
      check("rst_rvalid", {63'd0, bus1.resp_valid}, 64'd0);
      check("rst_ready",  {63'd0, bus1.req_ready}, 64'd1);

      // mtime after 10 idle cycles
      repeat (10) @(posedge clk);
      #1;
      txn(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 0, rd, er);
      check("mtime_10", rd, 64'd10);
      check("mtime_10_err", {63'd0, er}, 64'd0);
      check("mtime_10_mtip", {63'd0, mtip1}, 64'd0);

      // timer interrupt rises with mtime reaching 20
      txn(1'b1, BASE + 64'h4000, 64'd20, 8'hFF, 0, rd, er);
      check("cmp20_err", {63'd0, er}, 64'd0);
      for (int n = 0; n < 100 && cyc1 != 19; n++) begin @(posedge clk); #1; end
      check("reach_19", cyc1, 64'd19);
      check("mtip_at_19", {63'd0, mtip1}, 64'd0);
      @(posedge clk); #1;
      check("mtip_at_20", {63'd0, mtip1}, 64'd1);
      txn(1'b1, BASE + 64'h4000, 64'd1000, 8'hFF, 0, rd, er);
      check("mtip_cleared", {63'd0, mtip1}, 64'd0);

      // partial byte write
      txn(1'b1, BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, er);
      txn(1'b1, BASE + 64'h4000, 64'h1234, 8'h03, 0, rd, er);
      txn(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 0, rd, er);
      check("cmp_partial", rd, 64'hFFFF_FFFF_FFFF_1234);

      // unmapped accesses
      txn(1'b0, BASE + 64'h0008, 64'd0, 8'h00, 0, rd, er);
      check("unmap8_rdata", rd, 64'd0);
      check("unmap8_err", {63'd0, er}, 64'd1);
      txn(1'b0, BASE + 64'h10000, 64'd0, 8'h00, 0, rd, er);
      check("unmap64k_rdata", rd, 64'd0);
      check("unmap64k_err", {63'd0, er}, 64'd1);
      txn(1'b0, BASE - 64'd8, 64'd0, 8'h00, 0, rd, er);
      check("below_base_err", {63'd0, er}, 64'd1);
      txn(1'b1, BASE + 64'h4008, 64'd0, 8'hFF, 0, rd, er);
      check("unmap_wr_err", {63'd0, er}, 64'd1);
      txn(1'b1, BASE + 64'h4000, 64'd0, 8'h00, 0, rd, er);
      check("wstrb0_err", {63'd0, er}, 64'd0);
      txn(1'b0, BASE + 64'h4004, 64'd0, 8'h00, 5, rd, er);
      check("cmp_unchanged", rd, 64'hFFFF_FFFF_FFFF_1234);
      check("cmp_unchanged_err", {63'd0, er}, 64'd0);

      // software interrupt
      txn(1'b1, BASE, 64'd1, 8'h01, 0, rd, er);
      check("msip_set", {63'd0, msip1}, 64'd1);
      check("msip_wr_rdata", rd, 64'd0);
      txn(1'b1, BASE, 64'd0, 8'h02, 0, rd, er);
      check("msip_kept", {63'd0, msip1}, 64'd1);
      txn(1'b0, BASE, 64'd0, 8'h00, 0, rd, er);
      check("msip_read", rd, 64'd1);

      // reset while a response is pending
      wen = 1'b1; addr = BASE + 64'h4000; wdata = 64'd5; wstrb = 8'hFF; resp_ready = 1'b0;
      rv1 = 1'b1;
      @(posedge clk); #1;
      rv1 = 1'b0;
      check("pre_rst_rvalid", {63'd0, bus1.resp_valid}, 64'd1);
      rst1 = 1'b1;
      @(posedge clk); #1;
      rst1 = 1'b0;
      check("midrst_rvalid", {63'd0, bus1.resp_valid}, 64'd0);
      check("midrst_msip", {63'd0, msip1}, 64'd0);
      check("midrst_ready", {63'd0, bus1.req_ready}, 64'd1);
      check("midrst_mtip", {63'd0, mtip1}, 64'd0);
      txn(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 0, rd, er);
      check("midrst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);

      // prescaled instance and mtime wrap
      sel4 = 1'b1;
      check("rst4_mtip", {63'd0, mtip4}, 64'd0);
      @(posedge clk); #1;
      rst4 = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      txn(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 0, rd, er);
      check("div4_mtime_10", rd, 64'd10);
      txn(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, er);
      check("div4_wr_err", {63'd0, er}, 64'd0);
      check("div4_mtip_ones", {63'd0, mtip4}, 64'd1);
      repeat (2) @(posedge clk);
      #1;
      check("div4_mtip_hold", {63'd0, mtip4}, 64'd1);
      @(posedge clk); #1;
      check("div4_mtip_wrap", {63'd0, mtip4}, 64'd0);
      txn(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 0, rd, er);
      check("div4_mtime_wrap", rd, 64'd0);
      check("div4_msip", {63'd0, msip4}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
